teclado_senha: RTL and testbench

TECLADO_SENHA -- requirements
Module: teclado_senha

---
 rtl/fechadura_pkg.sv | 47 ++++
 rtl/varredura_matricial.sv | 153 +++++++++++++++
 rtl/teclado_senha.sv | 113 +++++++++++
 tb/tb_teclado_senha.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fechadura_pkg.sv
// Shared definitions for the electronic lock: password container, special
// key codes, keypad scan FSM states and small decoding helpers.
package fechadura_pkg;

    localparam int N_DIGITOS = 20;

    localparam logic [3:0] KEY_AST      = 4'hA;
    localparam logic [3:0] KEY_HASH     = 4'hB;
    localparam logic [3:0] DIGITO_VAZIO = 4'hF;

    // digits[0] is the newest digit; unused slots hold DIGITO_VAZIO
    typedef struct packed {
        logic [N_DIGITOS-1:0][3:0] digits;
    } senhaPac_t;

    typedef enum logic [1:0] {
        VARRE       = 2'd0,
        DEBOUNCE    = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTA       = 2'd3
    } estado_t;

    // Password with every slot empty
    function automatic senhaPac_t senha_vazia();
        senhaPac_t s;
        for (int i = 0; i < N_DIGITOS; i++) begin
            s.digits[i] = DIGITO_VAZIO;
        end
        return s;
    endfunction

    // Keypad position (row, column 0-2) to key code
    function automatic logic [3:0] mapa_tecla(input logic [1:0] lin, input logic [1:0] col);
        logic [3:0] codigo;
        if (lin == 2'd3) begin
            case (col)
                2'd0:    codigo = KEY_AST;
                2'd1:    codigo = 4'd0;
                default: codigo = KEY_HASH;
            endcase
        end else begin
            codigo = ({2'b00, lin} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return codigo;
    endfunction

endpackage

// File: rtl/varredura_matricial.sv
// 4x4 keypad scanner: row rotation, 2-flop column synchronizer, debounce and
// release filtering. Emits exactly one key_pulse per debounced key press.
module varredura_matricial
    import fechadura_pkg::*;
#(
    parameter int UM_SEGUNDO  = 1000,
    parameter int SCAN_CICLOS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_matricial,
    output logic [3:0] lin_matricial,
    output logic [3:0] key_code,
    output logic       key_pulse,
    output logic       em_debounce
);

    localparam int DEB_CICLOS = UM_SEGUNDO / 10;
    localparam int DW         = $clog2(DEB_CICLOS + 1);
    localparam int SW         = $clog2(SCAN_CICLOS + 1);

    logic [3:0]    col_s1_r;
    logic [3:0]    col_s2_r;
    estado_t       estado_r;
    logic [3:0]    lin_r;
    logic [SW-1:0] scan_cnt_r;
    logic [DW-1:0] deb_cnt_r;
    logic [1:0]    lin_lat_r;
    logic [1:0]    col_lat_r;
    logic [3:0]    key_code_r;
    logic          key_pulse_r;

    logic [1:0]    lin_atual_s;
    logic [1:0]    primeira_col_s;
    logic          tem_col_s;

    // Two-flop synchronizer for the asynchronous, pulled-up columns
    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_r <= 4'hF;
            col_s2_r <= 4'hF;
        end else begin
            col_s1_r <= col_matricial;
            col_s2_r <= col_s1_r;
        end
    end

    // Index of the row currently driven low
    always_comb begin
        case (lin_r)
            4'b1110: lin_atual_s = 2'd0;
            4'b1101: lin_atual_s = 2'd1;
            4'b1011: lin_atual_s = 2'd2;
            4'b0111: lin_atual_s = 2'd3;
            default: lin_atual_s = 2'd0;
        endcase
    end

    // Lowest low column among 0-2 wins; column 3 is not populated
    always_comb begin
        tem_col_s = 1'b1;
        if (!col_s2_r[0]) begin
            primeira_col_s = 2'd0;
        end else if (!col_s2_r[1]) begin
            primeira_col_s = 2'd1;
        end else if (!col_s2_r[2]) begin
            primeira_col_s = 2'd2;
        end else begin
            primeira_col_s = 2'd0;
            tem_col_s      = 1'b0;
        end
    end

    // Scan / debounce / hold / release state machine with registered outputs.
    // Columns are only trusted from the third cycle of a row on, once the
    // synchronizer reflects the row actually being driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r    <= VARRE;
            lin_r       <= 4'b1110;
            scan_cnt_r  <= '0;
            deb_cnt_r   <= '0;
            lin_lat_r   <= 2'd0;
            col_lat_r   <= 2'd0;
            key_code_r  <= 4'd0;
            key_pulse_r <= 1'b0;
        end else begin
            key_pulse_r <= 1'b0;
            case (estado_r)
                VARRE: begin
                    if ((scan_cnt_r >= SW'(2)) && tem_col_s) begin
                        lin_lat_r  <= lin_atual_s;
                        col_lat_r  <= primeira_col_s;
                        deb_cnt_r  <= '0;
                        scan_cnt_r <= '0;
                        estado_r   <= DEBOUNCE;
                    end else if (scan_cnt_r == SW'(SCAN_CICLOS - 1)) begin
                        scan_cnt_r <= '0;
                        lin_r      <= {lin_r[2:0], lin_r[3]};
                    end else begin
                        scan_cnt_r <= scan_cnt_r + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!col_s2_r[col_lat_r]) begin
                        if (deb_cnt_r == DW'(DEB_CICLOS - 1)) begin
                            key_pulse_r <= 1'b1;
                            key_code_r  <= mapa_tecla(lin_lat_r, col_lat_r);
                            deb_cnt_r   <= '0;
                            estado_r    <= PRESSIONADO;
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DW'(1);
                        end
                    end else begin
                        deb_cnt_r  <= '0;
                        scan_cnt_r <= '0;
                        estado_r   <= VARRE;
                    end
                end
                PRESSIONADO: begin
                    if (col_s2_r[col_lat_r]) begin
                        deb_cnt_r <= '0;
                        estado_r  <= SOLTA;
                    end else begin
                        estado_r <= PRESSIONADO;
                    end
                end
                SOLTA: begin
                    if (col_s2_r[2:0] != 3'b111) begin
                        deb_cnt_r <= '0;
                    end else if (deb_cnt_r == DW'(DEB_CICLOS - 1)) begin
                        deb_cnt_r  <= '0;
                        scan_cnt_r <= '0;
                        estado_r   <= VARRE;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DW'(1);
                    end
                end
                default: begin
                    estado_r   <= VARRE;
                    scan_cnt_r <= '0;
                    deb_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign lin_matricial = lin_r;
    assign key_code      = key_code_r;
    assign key_pulse     = key_pulse_r;
    assign em_debounce   = (estado_r == DEBOUNCE);

endmodule

// File: rtl/teclado_senha.sv
// Password keypad: collects debounced digits into a 20-digit buffer, clears
// it on '*' or inactivity, and publishes it on '#'.
module teclado_senha
    import fechadura_pkg::*;
#(
    parameter int UM_SEGUNDO  = 1000,
    parameter int SCAN_CICLOS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       teclado_en,
    input  logic [3:0] col_matricial,
    output logic [3:0] lin_matricial,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int TMAX = 5 * UM_SEGUNDO;
    localparam int TW   = $clog2(TMAX + 1);

    logic [3:0]    key_code_s;
    logic          key_pulse_s;
    logic          em_debounce_s;

    senhaPac_t     buf_r;
    senhaPac_t     valor_r;
    logic          valid_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          descarta_r;

    senhaPac_t     base_s;
    senhaPac_t     buf_nxt_s;
    senhaPac_t     valor_nxt_s;
    logic          valid_nxt_s;
    logic          buf_cheio_s;
    logic          expira_s;
    logic          evento_s;

    varredura_matricial #(
        .UM_SEGUNDO  (UM_SEGUNDO),
        .SCAN_CICLOS (SCAN_CICLOS)
    ) u_varredura (
        .clk           (clk),
        .rst           (rst),
        .col_matricial (col_matricial),
        .lin_matricial (lin_matricial),
        .key_code      (key_code_s),
        .key_pulse     (key_pulse_s),
        .em_debounce   (em_debounce_s)
    );

    assign buf_cheio_s = (buf_r.digits[0] != DIGITO_VAZIO);
    assign expira_s    = buf_cheio_s && (tmo_cnt_r == TW'(TMAX - 1));
    assign evento_s    = key_pulse_s && teclado_en && !descarta_r;
    // An expiring timeout clears first, so a same-cycle digit lands on an empty buffer
    assign base_s      = expira_s ? senha_vazia() : buf_r;

    // Next buffer / output contents from the accepted key event
    always_comb begin
        buf_nxt_s   = base_s;
        valor_nxt_s = valor_r;
        valid_nxt_s = 1'b0;
        if (!teclado_en) begin
            buf_nxt_s = senha_vazia();
        end else if (evento_s) begin
            if (key_code_s <= 4'd9) begin
                buf_nxt_s.digits = {base_s.digits[N_DIGITOS-2:0], key_code_s};
            end else if (key_code_s == KEY_AST) begin
                buf_nxt_s = senha_vazia();
            end else if (key_code_s == KEY_HASH) begin
                if (base_s.digits[0] != DIGITO_VAZIO) begin
                    valor_nxt_s = base_s;
                    valid_nxt_s = 1'b1;
                    buf_nxt_s   = senha_vazia();
                end else begin
                    buf_nxt_s = base_s;
                end
            end else begin
                buf_nxt_s = base_s;
            end
        end else begin
            buf_nxt_s = base_s;
        end
    end

    // Buffer, output register, inactivity timer and enable-drop tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r      <= senha_vazia();
            valor_r    <= senha_vazia();
            valid_r    <= 1'b0;
            tmo_cnt_r  <= '0;
            descarta_r <= 1'b0;
        end else begin
            buf_r   <= buf_nxt_s;
            valor_r <= valor_nxt_s;
            valid_r <= valid_nxt_s;
            // A debounce that saw the enable drop must not deliver its key
            descarta_r <= em_debounce_s && (descarta_r || !teclado_en);
            if (key_pulse_s) begin
                tmo_cnt_r <= '0;
            end else if (!buf_cheio_s || expira_s) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    assign digitos_value = valor_r;
    assign digitos_valid = valid_r;

endmodule

// File: tb/tb_teclado_senha.sv
// Self-checking bench for teclado_senha with a behavioural 4x4 keypad model.
module tb_teclado_senha;
    import fechadura_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       teclado_en = 1'b1;
    logic [3:0] col_matricial;
    logic [3:0] lin_matricial;
    senhaPac_t  digitos_value;
    logic       digitos_valid;

    // Keypad model: up to two keys held at once
    logic [3:0] tecla_a = 4'd0;
    logic [3:0] tecla_b = 4'd0;
    logic       prende_a = 1'b0;
    logic       prende_b = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_pulsos = 0;
    int erros_lin = 0;

    localparam logic [79:0] VAZIO = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    teclado_senha #(.UM_SEGUNDO(1000), .SCAN_CICLOS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .teclado_en    (teclado_en),
        .col_matricial (col_matricial),
        .lin_matricial (lin_matricial),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tecla_col(input logic p, input logic [3:0] k, input logic [3:0] lin);
        int r;
        int c;
        if (k == 4'hA) begin r = 3; c = 0; end
        else if (k == 4'd0) begin r = 3; c = 1; end
        else if (k == 4'hB) begin r = 3; c = 2; end
        else begin r = (int'(k) - 1) / 3; c = (int'(k) - 1) % 3; end
        if (p && (lin[r] == 1'b0)) return ~(4'b0001 << c);
        return 4'hF;
    endfunction

    assign col_matricial = tecla_col(prende_a, tecla_a, lin_matricial) &
                           tecla_col(prende_b, tecla_b, lin_matricial);

    always @(negedge clk) begin
        if (digitos_valid === 1'b1) n_pulsos++;
        if (!rst) begin
            case (lin_matricial)
                4'b1110, 4'b1101, 4'b1011, 4'b0111: ;
                default: erros_lin++;
            endcase
        end
    end

    task automatic check(input string nome, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic aperta(input logic [3:0] k, input int hold, input int gap);
        tecla_a = k;
        prende_a = 1'b1;
        espera(hold);
        prende_a = 1'b0;
        espera(gap);
    endtask

    function automatic logic [3:0] hexchar(input byte ch);
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        if (ch == "A") return 4'hA;
        return 4'hB;
    endfunction

    task automatic sequencia(input string s);
        for (int i = 0; i < s.len(); i++) aperta(hexchar(s[i]), 150, 150);
    endtask

    typedef struct {
        string       nome;
        string       teclas;
        logic        en;
        int          exp_pulsos;
        logic [79:0] exp_valor;
    } vetor_t;

    vetor_t tabela[7];

    initial begin
        int base;
        logic [3:0] lin_exp;

        tabela[0] = '{"v1234", "1234B", 1'b1, 1, 80'hFFFF_FFFF_FFFF_FFFF_1234};
        tabela[1] = '{"ast_clear", "12A9B", 1'b1, 1, 80'hFFFF_FFFF_FFFF_FFFF_FFF9};
        tabela[2] = '{"hash_empty", "B", 1'b1, 0, 80'hFFFF_FFFF_FFFF_FFFF_FFF9};
        tabela[3] = '{"v90", "90B", 1'b1, 1, 80'hFFFF_FFFF_FFFF_FFFF_FF90};
        tabela[4] = '{"wrap21", "123456789012345678905B", 1'b1, 1, 80'h2345_6789_0123_4567_8905};
        tabela[5] = '{"en_off", "12B", 1'b0, 0, 80'h2345_6789_0123_4567_8905};
        tabela[6] = '{"en_back", "3B", 1'b1, 1, 80'hFFFF_FFFF_FFFF_FFFF_FFF3};

        // Reset state
        rst = 1'b1;
        espera(3);
        check("rst_lin", 80'(lin_matricial), 80'(4'b1110));
        check("rst_value", digitos_value, VAZIO);
        check("rst_valid", 80'(digitos_valid), 80'd0);

        // Row rotation: SCAN_CICLOS=4 cycles per row
        rst = 1'b0;
        check("scan_r0", 80'(lin_matricial), 80'(4'b1110));
        lin_exp = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            espera(4);
            lin_exp = {lin_exp[2:0], lin_exp[3]};
            check("scan_rot", 80'(lin_matricial), 80'(lin_exp));
        end

        // Table-driven key sequences
        for (int v = 0; v < 7; v++) begin
            teclado_en = tabela[v].en;
            espera(2);
            base = n_pulsos;
            sequencia(tabela[v].teclas);
            check({tabela[v].nome, "_pulses"}, 80'(n_pulsos - base), 80'(tabela[v].exp_pulsos));
            check({tabela[v].nome, "_value"}, digitos_value, tabela[v].exp_valor);
            check({tabela[v].nome, "_valid_low"}, 80'(digitos_valid), 80'd0);
        end
        teclado_en = 1'b1;

        // Bouncing key 5 produces no event
        tecla_a = 4'd5;
        for (int i = 0; i < 8; i++) begin
            prende_a = 1'b1; espera(20);
            prende_a = 1'b0; espera(20);
        end
        espera(300);
        base = n_pulsos;
        sequencia("1B");
        check("bounce_pulses", 80'(n_pulsos - base), 80'd1);
        check("bounce_value", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF1);

        // Long hold of 7 gives a single digit
        base = n_pulsos;
        aperta(4'd7, 3000, 150);
        sequencia("B");
        check("hold_pulses", 80'(n_pulsos - base), 80'd1);
        check("hold_value", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF7);

        // Inactivity timeout clears the buffer silently
        base = n_pulsos;
        aperta(4'd8, 150, 5001);
        sequencia("B");
        check("timeout_pulses", 80'(n_pulsos - base), 80'd0);
        check("timeout_value", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF7);
        sequencia("2B");
        check("after_timeout", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF2);

        // Two columns of one row: lowest index (key 4 over key 6)
        tecla_a = 4'd4; tecla_b = 4'd6;
        prende_a = 1'b1; prende_b = 1'b1;
        espera(150);
        prende_a = 1'b0; prende_b = 1'b0;
        espera(150);
        sequencia("B");
        check("multi_col", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF4);

        // Enable dropping during debounce discards the pending key
        tecla_a = 4'd1;
        prende_a = 1'b1;
        espera(40);
        teclado_en = 1'b0;
        espera(20);
        teclado_en = 1'b1;
        espera(90);
        prende_a = 1'b0;
        espera(150);
        base = n_pulsos;
        sequencia("B");
        check("en_drop_pulses", 80'(n_pulsos - base), 80'd0);
        check("en_drop_value", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF4);

        // Reset mid-capture and mid-debounce discards everything
        sequencia("12");
        tecla_a = 4'd3;
        prende_a = 1'b1;
        espera(60);
        rst = 1'b1;
        espera(2);
        check("midrst_value", digitos_value, VAZIO);
        check("midrst_lin", 80'(lin_matricial), 80'(4'b1110));
        rst = 1'b0;
        espera(90);
        prende_a = 1'b0;
        espera(300);
        base = n_pulsos;
        sequencia("B");
        check("midrst_pulses", 80'(n_pulsos - base), 80'd0);
        sequencia("5B");
        check("midrst_after", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_FFF5);

        check("lin_one_low", 80'(erros_lin), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
